// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the multicycle multiply/divide unit.
package mdu_pkg;

  localparam logic MDU_MULT = 1'b0;
  localparam logic MDU_DIV  = 1'b1;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StCalc   = 2'd1;
  localparam state_t StFinish = 2'd2;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control unit (master) and the MDU (slave).
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes.
module mdu_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the result only when it did not borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    q_bit_o = ~diff[WIDTH+1];
    rem_o   = q_bit_o ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit producing HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_div_unit_if.slave bus_io
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             op_q, op_d;
  // Booth accumulator in the low WIDTH bits, or the partial remainder for DIV.
  logic [WIDTH:0]   rem_q, rem_d;
  // Booth multiplier shift register, or dividend-in / quotient-out shift register.
  logic [WIDTH-1:0] mq_q, mq_d;
  logic             qm1_q, qm1_d;
  // Multiplicand for MULT, divisor magnitude for DIV.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   step_rem;
  logic             step_qbit;
  logic [WIDTH-1:0] a_mag, b_mag;

  mdu_div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i    (rem_q),
    .bit_i    (mq_q[WIDTH-1]),
    .divisor_i(opnd_q),
    .rem_o    (step_rem),
    .q_bit_o  (step_qbit)
  );

  assign a_mag = bus_io.a[WIDTH-1] ? -bus_io.a : bus_io.a;
  assign b_mag = bus_io.b[WIDTH-1] ? -bus_io.b : bus_io.b;

  // Booth add/subtract done one bit wider so a MIN multiplicand cannot overflow before the shift.
  always_comb begin
    booth_sum = {rem_q[WIDTH-1], rem_q[WIDTH-1:0]};
    case ({mq_q[0], qm1_q})
      2'b01:   booth_sum = {rem_q[WIDTH-1], rem_q[WIDTH-1:0]} + {opnd_q[WIDTH-1], opnd_q};
      2'b10:   booth_sum = {rem_q[WIDTH-1], rem_q[WIDTH-1:0]} - {opnd_q[WIDTH-1], opnd_q};
      default: ;
    endcase
  end

  // FSM, iteration datapath and result fix-up.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    rem_d      = rem_q;
    mq_d       = mq_q;
    qm1_d      = qm1_q;
    opnd_d     = opnd_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          if (bus_io.op == MDU_DIV && bus_io.b == '0) begin
            // Complete immediately; HI/LO keep their previous contents.
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            op_d       = bus_io.op;
            div_zero_d = 1'b0;
            cnt_d      = CntW'(WIDTH);
            state_d    = StCalc;
            rem_d      = '0;
            qm1_d      = 1'b0;
            sign_a_d   = bus_io.a[WIDTH-1];
            sign_b_d   = bus_io.b[WIDTH-1];
            if (bus_io.op == MDU_MULT) begin
              mq_d   = bus_io.b;
              opnd_d = bus_io.a;
            end else begin
              mq_d   = a_mag;
              opnd_d = b_mag;
            end
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StFinish;
        end
        if (op_q == MDU_MULT) begin
          rem_d = {1'b0, booth_sum[WIDTH:1]};
          mq_d  = {booth_sum[0], mq_q[WIDTH-1:1]};
          qm1_d = mq_q[0];
        end else begin
          rem_d = step_rem;
          mq_d  = {mq_q[WIDTH-2:0], step_qbit};
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (op_q == MDU_MULT) begin
          hi_d = rem_q[WIDTH-1:0];
          lo_d = mq_q;
        end else begin
          lo_d = (sign_a_q ^ sign_b_q) ? -mq_q : mq_q;
          hi_d = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      rem_q      <= '0;
      mq_q       <= '0;
      qm1_q      <= 1'b0;
      opnd_q     <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      mq_q       <= mq_d;
      qm1_q      <= qm1_d;
      opnd_q     <= opnd_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus_io.busy     = (state_q != StIdle);
  assign bus_io.done     = done_q;
  assign bus_io.div_zero = div_zero_q;
  assign bus_io.hi       = hi_q;
  assign bus_io.lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32 = 1'b1;
  logic rst8  = 1'b1;

  mult_div_unit_if #(.WIDTH(32)) if32 ();
  mult_div_unit_if #(.WIDTH(8))  if8 ();

  mult_div_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(rst32), .bus_io(if32.slave));
  mult_div_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(rst8),  .bus_io(if8.slave));

  typedef struct {
    logic        dz;
    logic [63:0] hi;
    logic [63:0] lo;
    longint      e;
  } exp_t;

  exp_t        exp_q[2][$];
  logic [63:0] held_hi[2];
  logic [63:0] held_lo[2];
  logic        held_dz[2];
  int          tests = 0;
  int          fails = 0;
  longint      cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint sext(input logic [63:0] v, input int w);
    logic [63:0] sh;
    longint      t;
    sh = v << (64 - w);
    t  = $signed(sh);
    return t >>> (64 - w);
  endfunction

  // Reference: plain signed arithmetic; SV '/' and '%' truncate toward zero like the MDU.
  function automatic void model(input logic op, input logic [63:0] a, input logic [63:0] b,
                                input int w, output logic [63:0] hi, output logic [63:0] lo);
    longint      sa, sb, res, rem;
    logic [63:0] mask, u;
    mask = (64'd1 << w) - 64'd1;
    sa   = sext(a, w);
    sb   = sext(b, w);
    if (op == MDU_MULT) begin
      res = sa * sb;
      u   = res;
      hi  = (u >> w) & mask;
      lo  = u & mask;
    end else begin
      res = sa / sb;
      rem = sa % sb;
      u   = rem;
      hi  = u & mask;
      u   = res;
      lo  = u & mask;
    end
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask, v;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       v = 64'd1 << (w - 1);
      1:       v = mask;
      2:       v = (64'd1 << (w - 1)) - 64'd1;
      default: v = {$urandom, $urandom} & mask;
    endcase
    return v;
  endfunction

  task automatic mon(input int d, input logic rst, input logic done, input logic busy,
                     input logic dz, input logic [63:0] hi, input logic [63:0] lo, input int w);
    exp_t  x;
    logic  busy_exp;
    string tag;
    tag = (w == 32) ? "w32" : "w8";
    if (rst) begin
      exp_q[d].delete();
      held_hi[d] = '0;
      held_lo[d] = '0;
      held_dz[d] = 1'b0;
      check({tag, " reset busy"}, 64'(busy), 64'd0);
      check({tag, " reset done"}, 64'(done), 64'd0);
      check({tag, " reset div_zero"}, 64'(dz), 64'd0);
      check({tag, " reset hi"}, hi, 64'd0);
      check({tag, " reset lo"}, lo, 64'd0);
    end else begin
      busy_exp = 1'b0;
      if (exp_q[d].size() > 0) begin
        x = exp_q[d][0];
        busy_exp = !x.dz && cyc >= x.e && cyc <= x.e + w;
        if (!x.dz && cyc >= x.e) held_dz[d] = 1'b0;
      end
      check({tag, " busy"}, 64'(busy), 64'(busy_exp));
      if (done) begin
        if (exp_q[d].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL %s unexpected done: got done=1, expected 0 (cycle %0d)", tag, cyc);
        end else begin
          x = exp_q[d].pop_front();
          check({tag, " done cycle"}, 64'(cyc), 64'(x.dz ? x.e : x.e + w + 1));
          if (x.dz) begin
            held_dz[d] = 1'b1;
          end else begin
            held_hi[d] = x.hi;
            held_lo[d] = x.lo;
          end
          check({tag, " result hi"}, hi, held_hi[d]);
          check({tag, " result lo"}, lo, held_lo[d]);
        end
      end else begin
        check({tag, " hold hi"}, hi, held_hi[d]);
        check({tag, " hold lo"}, lo, held_lo[d]);
      end
      check({tag, " div_zero"}, 64'(dz), 64'(held_dz[d]));
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst32, if32.done, if32.busy, if32.div_zero, 64'(if32.hi), 64'(if32.lo), 32);
    mon(1, rst8, if8.done, if8.busy, if8.div_zero, 64'(if8.hi), 64'(if8.lo), 8);
  end

  // Drive one start pulse; if accept, record what the DUT must eventually present.
  task automatic issue(input int d, input logic op, input logic [63:0] a, input logic [63:0] b,
                       input bit sync, input bit accept, output longint e);
    exp_t        x;
    logic [63:0] hi, lo, mask;
    int          w;
    w    = (d == 0) ? 32 : 8;
    mask = (64'd1 << w) - 64'd1;
    if (sync) @(negedge clk);
    #1;
    if (d == 0) begin
      if32.start = 1'b1; if32.op = op; if32.a = a[31:0]; if32.b = b[31:0];
    end else begin
      if8.start = 1'b1; if8.op = op; if8.a = a[7:0]; if8.b = b[7:0];
    end
    @(posedge clk);
    #1;
    e = cyc;
    if (d == 0) if32.start = 1'b0;
    else        if8.start = 1'b0;
    if (accept) begin
      x.e  = e;
      x.dz = (op == MDU_DIV) && ((b & mask) == 64'd0);
      x.hi = '0;
      x.lo = '0;
      if (!x.dz) begin
        model(op, a & mask, b & mask, w, hi, lo);
        x.hi = hi;
        x.lo = lo;
      end
      exp_q[d].push_back(x);
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (exp_q[d].size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[d].size() > 0) begin
      tests++;
      fails++;
      $display("FAIL dut%0d completion timeout: got %0d pending, expected 0", d, exp_q[d].size());
      exp_q[d].delete();
    end
  endtask

  task automatic run(input int d, input logic op, input logic [63:0] a, input logic [63:0] b);
    longint e;
    issue(d, op, a, b, 1'b1, 1'b1, e);
    wait_idle(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    longint      e;
    int          n;
    logic        op;
    logic [63:0] a, b;
    if32.start = 1'b0; if32.op = 1'b0; if32.a = '0; if32.b = '0;
    if8.start  = 1'b0; if8.op  = 1'b0; if8.a  = '0; if8.b  = '0;
    repeat (3) @(negedge clk);
    #1;
    rst32 = 1'b0;
    rst8  = 1'b0;

    // Directed products and quotients.
    run(0, MDU_MULT, 64'd7, 64'hFFFF_FFFD);
    run(0, MDU_MULT, 64'h8000_0000, 64'h8000_0000);
    run(0, MDU_DIV, 64'hFFFF_FFF9, 64'd2);
    run(0, MDU_DIV, 64'h8000_0000, 64'hFFFF_FFFF);

    // Divide by zero leaves HI/LO at 1/2, next accepted start clears the flag.
    run(0, MDU_DIV, 64'd5, 64'd2);
    run(0, MDU_DIV, 64'd5, 64'd0);
    repeat (3) @(negedge clk);
    run(0, MDU_MULT, 64'd3, 64'd4);

    // A start while busy is ignored.
    issue(0, MDU_MULT, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1, 1'b1, e);
    repeat (4) @(posedge clk);
    issue(0, MDU_DIV, 64'd100, 64'd7, 1'b1, 1'b0, e);
    wait_idle(0);

    // Back-to-back start in the done cycle.
    issue(0, MDU_DIV, 64'd1000, 64'hFFFF_FFFD, 1'b1, 1'b1, e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if32.done && n < 100);
    issue(0, MDU_MULT, 64'hFFFF_FFFF, 64'h7FFF_FFFF, 1'b0, 1'b1, e);
    wait_idle(0);

    // Reset in the middle of a MULT aborts it.
    issue(0, MDU_MULT, 64'd11, 64'd13, 1'b1, 1'b1, e);
    repeat (9) @(posedge clk);
    @(negedge clk);
    #1;
    rst32 = 1'b1;
    @(negedge clk);
    #1;
    rst32 = 1'b0;
    repeat (40) @(negedge clk);
    run(0, MDU_MULT, 64'd11, 64'd13);

    // Randomised mix at WIDTH=32.
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = pick(32);
      b  = pick(32);
      if ($urandom_range(0, 7) == 0) b = '0;
      run(0, op, a, b);
    end

    // WIDTH=8.
    run(1, MDU_MULT, 64'h80, 64'hFF);
    run(1, MDU_DIV, 64'h80, 64'hFF);
    run(1, MDU_DIV, 64'h81, 64'h00);
    for (int i = 0; i < 30; i++) begin
      op = 1'($urandom_range(0, 1));
      a  = pick(8);
      b  = pick(8);
      if ($urandom_range(0, 7) == 0) b = '0;
      run(1, op, a, b);
    end

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
